// File: rtl/ct_spsram_512x59_ctrl.sv
// rtl/ct_spsram_512x59_ctrl.sv - Single-port 512x59 SRAM arbiter with hardware clear sequence
module ct_spsram_512x59_ctrl #(
  parameter int ADDR_WIDTH   = 9,
  parameter int DATA_WIDTH   = 59,
  parameter int DEPTH        = 512,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  init_req,
  output logic                  init_busy,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_gnt,
  output logic                  rd_vld,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [DATA_WIDTH-1:0] wr_mask,
  output logic                  wr_gnt,
  output logic                  ram_cen,
  output logic                  ram_gwen,
  output logic [DATA_WIDTH-1:0] ram_wen,
  output logic [ADDR_WIDTH-1:0] ram_a,
  output logic [DATA_WIDTH-1:0] ram_d,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  typedef enum logic {IDLE = 1'b0, INIT = 1'b1} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [2:0]            STARVE_MAX = 3'(STARVE_LIMIT);

  state_t                  state, state_nxt;
  logic                    init_pend;
  logic [ADDR_WIDTH-1:0]   init_cnt;
  logic [2:0]              starve_cnt;
  logic [ADDR_WIDTH-1:0]   a_hold;
  logic [DATA_WIDTH-1:0]   d_hold;
  logic                    arb_en;
  logic                    wr_wins;

  assign arb_en    = (state == IDLE) && !init_pend;
  assign wr_wins   = (starve_cnt >= STARVE_MAX);
  assign rd_gnt    = arb_en && rd_req && !(wr_req && wr_wins);
  assign wr_gnt    = arb_en && wr_req && (!rd_req || wr_wins);
  assign init_busy = init_pend || (state == INIT);
  assign rd_data   = rd_vld ? ram_q : '0;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (init_pend || init_req) state_nxt = INIT;
      INIT:    if (init_cnt == LAST_ADDR) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Address/data fall back to the previous cycle's value when idle to avoid pin toggling.
  always_comb begin
    ram_cen  = 1'b1;
    ram_gwen = 1'b1;
    ram_wen  = '1;
    ram_a    = a_hold;
    ram_d    = d_hold;
    if (state == INIT) begin
      ram_cen  = 1'b0;
      ram_gwen = 1'b0;
      ram_wen  = '0;
      ram_a    = init_cnt;
      ram_d    = '0;
    end else if (wr_gnt) begin
      ram_cen  = 1'b0;
      ram_gwen = 1'b0;
      ram_wen  = ~wr_mask;
      ram_a    = wr_addr;
      ram_d    = wr_data;
    end else if (rd_gnt) begin
      ram_cen  = 1'b0;
      ram_a    = rd_addr;
    end
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state      <= IDLE;
      init_pend  <= 1'b1;
      init_cnt   <= '0;
      starve_cnt <= '0;
      rd_vld     <= 1'b0;
      a_hold     <= '0;
      d_hold     <= '0;
    end else begin
      state  <= state_nxt;
      rd_vld <= rd_gnt;
      a_hold <= ram_a;
      d_hold <= ram_d;
      if (state == IDLE && state_nxt == INIT)
        init_pend <= 1'b0;
      if (state == INIT)
        init_cnt <= (init_cnt == LAST_ADDR) ? '0 : init_cnt + ADDR_WIDTH'(1);
      if (!wr_req || wr_gnt)
        starve_cnt <= '0;
      else if (state == IDLE && starve_cnt != 3'd7)
        starve_cnt <= starve_cnt + 3'd1;
    end
  end

endmodule

// File: doc/ct_spsram_512x59_ctrl.md
Name: ct_spsram_512x59_ctrl

Overview:
- Access controller and arbiter for one 512x59 single-port SRAM: active-low CEN/GWEN, per-bit active-low WEN, Q valid the cycle after a read access.
- Shares the single port between one read requester (lookup path) and one write requester (refill/update path).
- Runs a hardware clear sequence that writes zero to all 512 entries after reset or on request.
- Sits between the owning pipeline and the SRAM wrapper. All SRAM pins are driven only by this block.

Parameters:
ADDR_WIDTH, 9, SRAM address width
DATA_WIDTH, 59, SRAM word width
DEPTH, 512, entries cleared by the init sequence (2^ADDR_WIDTH)
STARVE_LIMIT, 4, contended cycles a write may lose to reads before it is forced to win

Ports:
forever_cpuclk  in  1  clock
cpurst_b  in  1  asynchronous active-low reset
init_req  in  1  one-cycle pulse: start clear sequence
init_busy  out  1  clear pending or in progress; all requests refused
rd_req  in  1  read request; held until granted
rd_addr  in  ADDR_WIDTH  read address
rd_gnt  out  1  read issued to SRAM this cycle
rd_vld  out  1  rd_data valid (cycle after rd_gnt)
rd_data  out  DATA_WIDTH  read data
wr_req  in  1  write request; held until granted
wr_addr  in  ADDR_WIDTH  write address
wr_data  in  DATA_WIDTH  write data
wr_mask  in  DATA_WIDTH  per-bit write enable, 1 = write bit
wr_gnt  out  1  write issued to SRAM this cycle
ram_cen  out  1  SRAM chip enable, active low
ram_gwen  out  1  SRAM global write enable, active low
ram_wen  out  DATA_WIDTH  SRAM bit write enable, active low
ram_a  out  ADDR_WIDTH  SRAM address
ram_d  out  DATA_WIDTH  SRAM write data
ram_q  in  DATA_WIDTH  SRAM read data

Behaviour:
- Clock and reset: single clock forever_cpuclk; reset cpurst_b is asynchronous, active low.
- Reset values:
  - state = IDLE, init_pend = 1, init counter = 0, starve counter = 0, rd_vld = 0.
  - Outputs during reset: ram_cen = 1, ram_gwen = 1, ram_wen = all ones, ram_a = 0, ram_d = 0, grants = 0, init_busy = 1.
- States: IDLE and INIT.
  - IDLE -> INIT when init_pend is set, or when init_req = 1 in IDLE. init_pend clears on entry to INIT.
  - INIT -> IDLE on the cycle that writes address DEPTH-1.
- INIT cycle:
  - Drives ram_cen = 0, ram_gwen = 0, ram_wen = all zero, ram_d = 0, ram_a = init counter.
  - Counter increments each cycle and wraps to 0 on exit.
  - Clear takes exactly DEPTH cycles; init_busy is 1 throughout.
  - init_req during INIT is ignored.
  - rd_gnt and wr_gnt are 0 in INIT and while init_pend = 1.
- IDLE arbitration (combinational, same cycle):
  - Only rd_req -> rd_gnt = 1. Only wr_req -> wr_gnt = 1.
  - Both requesting: read wins unless starve counter >= STARVE_LIMIT, in which case write wins.
  - At most one grant per cycle. A requester must hold req and address/data stable until its grant.
- Starve counter (3 bits, saturating):
  - Increments when wr_req = 1 and wr_gnt = 0 in IDLE.
  - Clears on wr_gnt, or when wr_req = 0.
  - Under continuous contention: reads win 4 cycles, the write wins the 5th.
- SRAM drive:
  - Read grant: ram_cen = 0, ram_gwen = 1, ram_wen = all ones, ram_a = rd_addr.
  - Write grant: ram_cen = 0, ram_gwen = 0, ram_wen = ~wr_mask, ram_a = wr_addr, ram_d = wr_data.
  - No grant and not INIT: ram_cen = 1, ram_gwen = 1, ram_wen = all ones. ram_a and ram_d hold their last values (registered mux select) to limit toggling.
- Read return:
  - rd_vld is a flop of rd_gnt (1-cycle latency).
  - rd_data = ram_q while rd_vld = 1, else 0.
  - Back-to-back reads give one rd_vld per cycle.
- Ordering: a write granted in cycle N followed by a read of the same address in N+1 returns the new data. There is no bypass; the SRAM's write-then-read ordering provides this.
- init_req in the same cycle as requests in IDLE: the request is granted that cycle. INIT begins the next cycle.
- Reset mid-INIT aborts the clear. init_pend = 1 after release, so a full clear restarts from address 0.
- wr_mask all zero on a granted write: access is still issued (ram_gwen = 0, ram_wen = all ones) and no bits change.

Test Plan:
- Reset release -> one idle cycle, then 512 cycles with ram_cen = 0, ram_gwen = 0, ram_a = 0..511, ram_d = 0; init_busy falls after address 511; rd_req held throughout is granted on the first IDLE cycle.
- Write addr 0x1A5, data 0x7FF_FFFF_FFFF_FFFF (all 59 bits set), mask all ones; then read 0x1A5 -> rd_vld one cycle after rd_gnt, rd_data = all ones.
- Masked write to 0x1A5: data 0, mask 0x000_0000_0000_00FF -> read returns 0x7FF_FFFF_FFFF_FF00.
- rd_req and wr_req held continuously (STARVE_LIMIT = 4) -> rd_gnt in cycles 0-3, wr_gnt in cycle 4, counter cleared, pattern repeats.
- init_req pulse during read traffic -> grants drop the next cycle for 512 cycles; a previously written location reads 0 afterwards.
- cpurst_b asserted at init counter = 200 -> all SRAM controls inactive immediately; after release the clear restarts at address 0 and runs 512 cycles.
